decode_queue: RTL and testbench
===============================

# decode_queue

Registered instruction-decode stage for the turtle CPU. It accepts raw instruction words over a valid/ready handshake, splits them into branch, opcode, function, register-address and immediate fields, and flags illegal encodings. Decoded entries are buffered in a parametrised FIFO ahead of the execute stage, with a flush path for taken jumps and a saturating illegal-instruction counter. It generalises the fixed 16-bit field map to a configurable instruction width and queue depth.

## Interface
- INSTR_WIDTH, 16, instruction word width; must be ≥ 16; immediates widen with it
- DEPTH, 2, decoded-entry FIFO depth; power of two, 1..16
- CNT_WIDTH, 8, width of illegal-instruction counter
- clk  in  1  single clock; everything is rising-edge
- rst  in  1  asynchronous, active-high reset
- flush_i  in  1  discard all buffered entries and any same-cycle input
- in_valid  in  1  in_instr is valid
- in_ready  out  1  stage can accept an instruction
- in_instr  in  INSTR_WIDTH  raw instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  consumer takes the head entry
- out_is_branch  out  1  head instr[0]
- out_cond  out  3  head instr[3:1], branch condition
- out_opcode  out  3  head instr[3:1], opcode
- out_func  out  4  head instr[7:4], ALU or reg/mem function
- out_reg_addr  out  4  head instr[11:8]
- out_data_imm  out  INSTR_WIDTH-8  head instr[INSTR_WIDTH-1:8]
- out_addr_imm  out  INSTR_WIDTH-4  head instr[INSTR_WIDTH-1:4]
- out_illegal  out  1  head entry is an illegal encoding
- occupancy  out  $clog2(DEPTH+1)  entries held
- illegal_count  out  CNT_WIDTH  illegal instructions accepted since reset, saturating

## Operation
- Fields are extracted raw from every word; consumers qualify cond by out_is_branch and opcode/func by !out_is_branch.
- Legal opcodes with instr[0]=0: 000 ALU-imm, 001 ALU, 010 reg/mem, 100 jump-imm, 111 jump-reg.
- Illegal when instr[0]=0 and either:
  - opcode ∈ {011, 101, 110}; or
  - opcode = 010 and func > 4'b0100 (LOAD/STORE/GET/PUT/SET only).
- Branch words (instr[0]=1) are never illegal.
- Illegal words are still queued, with out_illegal=1; fields are passed through unchanged.
- Accept = in_valid & in_ready. in_ready = (occupancy < DEPTH) & !flush_i. No combinational input-to-output pass-through.
- Pop = out_valid & out_ready. out_valid = (occupancy != 0).
- The FIFO uses circular read/write pointers that wrap at DEPTH. Push and pop in the same cycle leave occupancy unchanged. Order is strictly preserved.
- While empty, all out_* field outputs read 0.
- flush_i has priority over push and pop:
  - pointers and occupancy go to 0 on the next edge;
  - no same-cycle word is accepted;
  - illegal_count is unaffected.
- illegal_count increments by 1 on each accepted illegal word and holds at 2^CNT_WIDTH−1.
- States are implicit: EMPTY (occ=0), PARTIAL, FULL (occ=DEPTH).
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on push without pop.
  - FULL→PARTIAL on pop.
  - Any state→EMPTY on flush.
  - When DEPTH=1, EMPTY↔FULL directly.

## Timing
- Reset (async assert, output values immediate): out_valid=0, occupancy=0, illegal_count=0, all out_* fields 0, in_ready=1 (unless flush_i is asserted).
- Latency: a word accepted at edge N is on the outputs with out_valid=1 after edge N, i.e. visible in cycle N+1.
- Throughput: one word per cycle while out_ready=1.
- When FULL, in_ready=0 even if out_ready=1. The popped slot is refilled one cycle later, so DEPTH≥2 is required for full throughput.
- Reset asserted mid-stream drops all entries immediately. The first accept after deassertion occurs at the next edge.

## Test plan
- Reset check: assert rst while the FIFO holds 2 entries -> out_valid=0, occupancy=0, illegal_count=0, in_ready=1 without waiting for a clock edge.
- ALU-imm decode: in_instr=16'h5A10 accepted at edge N -> in cycle N+1: out_valid=1, opcode=000, func=1, reg_addr=0xA, data_imm=8'h5A, illegal=0.
- Branch decode: 16'hABC7 -> out_is_branch=1, cond=3'b011, addr_imm=12'hABC, illegal=0.
- Illegal detection: 16'h0006 then 16'h0054 -> both queued with out_illegal=1 and illegal_count=2. With CNT_WIDTH=2, 5 illegal words -> illegal_count=3 (saturated).
- Backpressure with DEPTH=2 and out_ready=0:
  - offer 16'h0010, 16'h0020, 16'h0030 -> in_ready=0 after the second accept, occupancy=2;
  - then out_ready=1 -> outputs 0x0010, 0x0020, 0x0030 in order, no loss or duplication.
- Flush: occupancy=2 with in_valid=1 and flush_i=1 -> in_ready=0 that cycle; next cycle occupancy=0, out_valid=0; illegal_count unchanged.

Source files
------------

// File: rtl/decode_queue.sv
// Instruction-decode stage for the turtle CPU. Raw words are classified as they arrive and
// buffered in a circular FIFO; the head entry's fields are presented to the execute stage.
//
//   state   | meaning
//   EMPTY   | occupancy == 0, out_valid low, all field outputs forced to 0
//   PARTIAL | 0 < occupancy < DEPTH, accepting and presenting
//   FULL    | occupancy == DEPTH, in_ready low even while popping
module decode_queue #(
    parameter int INSTR_WIDTH = 16,
    parameter int DEPTH       = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_is_branch,
    output logic [2:0]                   out_cond,
    output logic [2:0]                   out_opcode,
    output logic [3:0]                   out_func,
    output logic [3:0]                   out_reg_addr,
    output logic [INSTR_WIDTH-9:0]       out_data_imm,
    output logic [INSTR_WIDTH-5:0]       out_addr_imm,
    output logic                         out_illegal,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [CNT_WIDTH-1:0]         illegal_count
);

    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_ALU_IMM  = 3'b000;
    localparam logic [2:0] OP_ALU      = 3'b001;
    localparam logic [2:0] OP_REG_MEM  = 3'b010;
    localparam logic [2:0] OP_JUMP_IMM = 3'b100;
    localparam logic [2:0] OP_JUMP_REG = 3'b111;
    localparam logic [3:0] FUNC_MEM_MAX = 4'b0100;

    logic [INSTR_WIDTH-1:0] word_mem [DEPTH];
    logic                   ill_mem  [DEPTH];

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;
    logic [CNT_WIDTH-1:0] ill_cnt_q, ill_cnt_d;

    logic                   push;
    logic                   pop;
    logic                   in_illegal;
    logic [INSTR_WIDTH-1:0] head_word;
    logic                   head_illegal;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Branch words are always legal; reg/mem only defines LOAD..SET (func 0..4).
    function automatic logic decode_illegal(input logic [INSTR_WIDTH-1:0] w);
        logic [2:0] op;
        logic [3:0] fn;
        logic       ill;
        op  = w[3:1];
        fn  = w[7:4];
        ill = 1'b0;
        if (!w[0]) begin
            case (op)
                OP_ALU_IMM, OP_ALU, OP_JUMP_IMM, OP_JUMP_REG: ill = 1'b0;
                OP_REG_MEM:                                   ill = (fn > FUNC_MEM_MAX);
                default:                                      ill = 1'b1;
            endcase
        end
        return ill;
    endfunction

    assign in_illegal = decode_illegal(in_instr);
    assign in_ready   = (occ_q < OCC_W'(DEPTH)) && !flush_i;
    assign out_valid  = (occ_q != '0);
    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign occupancy  = occ_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        ill_cnt_d = ill_cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_d = occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_d = occ_q - 1'b1;
            end
        end
        if (push && in_illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            ill_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            ill_cnt_q <= ill_cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= in_instr;
            ill_mem[wr_ptr_q]  <= in_illegal;
        end
    end

    assign illegal_count = ill_cnt_q;

    always_comb begin
        head_word    = '0;
        head_illegal = 1'b0;
        if (out_valid) begin
            head_word    = word_mem[rd_ptr_q];
            head_illegal = ill_mem[rd_ptr_q];
        end
    end

    assign out_is_branch = head_word[0];
    assign out_cond      = head_word[3:1];
    assign out_opcode    = head_word[3:1];
    assign out_func      = head_word[7:4];
    assign out_reg_addr  = head_word[11:8];
    assign out_data_imm  = head_word[INSTR_WIDTH-1:8];
    assign out_addr_imm  = head_word[INSTR_WIDTH-1:4];
    assign out_illegal   = head_illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios followed by randomized traffic,
// compared each cycle against a queue-based reference model.
module tb_decode_queue;

    localparam int IW    = 16;
    localparam int DEPTH = 2;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic            flush_i;
    logic            in_valid;
    logic            in_ready;
    logic [IW-1:0]   in_instr;
    logic            out_valid;
    logic            out_ready;
    logic            out_is_branch;
    logic [2:0]      out_cond;
    logic [2:0]      out_opcode;
    logic [3:0]      out_func;
    logic [3:0]      out_reg_addr;
    logic [IW-9:0]   out_data_imm;
    logic [IW-5:0]   out_addr_imm;
    logic            out_illegal;
    logic [$clog2(DEPTH+1)-1:0] occupancy;
    logic [CW-1:0]   illegal_count;

    int total = 0;
    int bad   = 0;

    logic [IW-1:0] mq[$];
    int            mcnt = 0;

    decode_queue #(.INSTR_WIDTH(IW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_is_branch(out_is_branch), .out_cond(out_cond), .out_opcode(out_opcode),
        .out_func(out_func), .out_reg_addr(out_reg_addr),
        .out_data_imm(out_data_imm), .out_addr_imm(out_addr_imm),
        .out_illegal(out_illegal), .occupancy(occupancy), .illegal_count(illegal_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_illegal(input logic [IW-1:0] w);
        int op;
        int fn;
        op = int'(w[3:1]);
        fn = int'(w[7:4]);
        if (w[0]) return 1'b0;
        if (op == 3 || op == 5 || op == 6) return 1'b1;
        if (op == 2 && fn > 4) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        logic [IW-1:0] h;
        h = (mq.size() != 0) ? mq[0] : '0;
        check_val("in_ready", 32'(in_ready), 32'((mq.size() < DEPTH) && !flush_i));
        check_val("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        check_val("occupancy", 32'(occupancy), 32'(mq.size()));
        check_val("illegal_count", 32'(illegal_count), 32'(mcnt));
        check_val("is_branch", 32'(out_is_branch), 32'(h[0]));
        check_val("cond", 32'(out_cond), 32'(h[3:1]));
        check_val("opcode", 32'(out_opcode), 32'(h[3:1]));
        check_val("func", 32'(out_func), 32'(h[7:4]));
        check_val("reg_addr", 32'(out_reg_addr), 32'(h[11:8]));
        check_val("data_imm", 32'(out_data_imm), 32'(h[15:8]));
        check_val("addr_imm", 32'(out_addr_imm), 32'(h[15:4]));
        check_val("illegal", 32'(out_illegal), 32'((mq.size() != 0) && ref_illegal(h)));
    endtask

    // Entered and left one time unit after a rising edge.
    task automatic step(input logic v, input logic [IW-1:0] w, input logic r, input logic f);
        bit acc;
        bit pop;
        in_valid  = v;
        in_instr  = w;
        out_ready = r;
        flush_i   = f;
        @(negedge clk);
        check_outputs();
        acc = v && (mq.size() < DEPTH) && !f;
        pop = r && (mq.size() != 0);
        @(posedge clk);
        if (f) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(w);
                if (ref_illegal(w) && mcnt < CMAX) mcnt++;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b0;
        #2;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // ALU-imm decode, then branch decode
        step(1'b1, 16'h5A10, 1'b0, 1'b0);
        check_val("aluimm_valid", 32'(out_valid), 32'd1);
        check_val("aluimm_opcode", 32'(out_opcode), 32'd0);
        check_val("aluimm_func", 32'(out_func), 32'd1);
        check_val("aluimm_reg", 32'(out_reg_addr), 32'hA);
        check_val("aluimm_imm", 32'(out_data_imm), 32'h5A);
        check_val("aluimm_ill", 32'(out_illegal), 32'd0);
        step(1'b1, 16'hABC7, 1'b1, 1'b0);
        check_val("br_is_branch", 32'(out_is_branch), 32'd1);
        check_val("br_cond", 32'(out_cond), 32'd3);
        check_val("br_addr_imm", 32'(out_addr_imm), 32'hABC);
        check_val("br_ill", 32'(out_illegal), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0);

        // Illegal detection and saturation
        step(1'b1, 16'h0006, 1'b0, 1'b0);
        check_val("ill_0006", 32'(out_illegal), 32'd1);
        step(1'b1, 16'h0054, 1'b1, 1'b0);
        check_val("ill_0054", 32'(out_illegal), 32'd1);
        check_val("ill_count2", 32'(illegal_count), 32'd2);
        step(1'b1, 16'h000A, 1'b1, 1'b0);
        step(1'b1, 16'h000C, 1'b1, 1'b0);
        step(1'b1, 16'h0064, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("ill_count_sat", 32'(illegal_count), 32'd3);

        // Backpressure and ordering
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        check_val("bp_occ", 32'(occupancy), 32'd2);
        check_val("bp_ready", 32'(in_ready), 32'd0);
        step(1'b1, 16'h0030, 1'b0, 1'b0);
        step(1'b1, 16'h0030, 1'b1, 1'b0);
        check_val("bp_head2", 32'(out_addr_imm), 32'h002);
        step(1'b1, 16'h0030, 1'b1, 1'b0);
        check_val("bp_head3", 32'(out_addr_imm), 32'h003);
        step(1'b0, '0, 1'b1, 1'b0);
        check_val("bp_drained", 32'(out_valid), 32'd0);

        // Flush with a full queue and a same-cycle offer
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        step(1'b1, 16'h0020, 1'b0, 1'b0);
        step(1'b1, 16'h0040, 1'b0, 1'b1);
        check_val("flush_occ", 32'(occupancy), 32'd0);
        check_val("flush_valid", 32'(out_valid), 32'd0);
        check_val("flush_cnt", 32'(illegal_count), 32'd3);
        step(1'b0, '0, 1'b0, 1'b0);

        // Asynchronous reset mid-stream
        step(1'b1, 16'h0006, 1'b0, 1'b0);
        step(1'b1, 16'h0010, 1'b0, 1'b0);
        check_val("pre_rst_occ", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_occ", 32'(occupancy), 32'd0);
        check_val("rst_cnt", 32'(illegal_count), 32'd0);
        check_val("rst_ready", 32'(in_ready), 32'd1);
        check_val("rst_fields", 32'(out_addr_imm), 32'd0);
        mq.delete();
        mcnt = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        check_val("post_rst_accept", 32'(occupancy), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, IW'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
